// File: rtl/sample_strobe_gen.sv
// sample_strobe_gen
// Generates the sample-rate strobe from acq_enable / clock_select / clock_divisor.
// It captures the synchronized channel inputs on each strobe and presents every
// captured word on a valid/ready output register. If the consumer stalls and a
// strobe finds the output register still full, the strobe is dropped and a
// sticky overflow flag is raised.
module sample_strobe_gen #(
  parameter int WIDTH       = 16,
  parameter int PRESCALE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acq_enable,
  input  logic             clock_select,
  input  logic [7:0]       clock_divisor,
  input  logic [WIDTH-1:0] channels,
  output logic [WIDTH-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overflow,
  output logic [15:0]      sample_count,
  output logic             running
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_RELOAD = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_OVERFLOW
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic             acq_q;
  logic             acqPrev_q;
  logic             sel_q, sel_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [7:0]       div_q, div_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      count_q, count_d;

  logic startPulse;
  logic baseTick;
  logic strobe;
  logic lost;
  logic capture;

  // Channel synchronizer chain and the single-stage acq_enable register
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      acq_q     <= 1'b0;
      acqPrev_q <= 1'b0;
    end else begin
      sync_q[0] <= channels;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      acq_q     <= acq_enable;
      acqPrev_q <= acq_q;
    end
  end

  // Strobe qualification: counters only advance in RUN while acquisition is on
  always_comb begin
    startPulse = acq_q & ~acqPrev_q;
    baseTick   = (state_q == ST_RUN) && (sel_q || (pre_q == '0));
    strobe     = baseTick && acq_q && (div_q == 8'd0);
    lost       = strobe & valid_q & ~sample_ready;
    capture    = strobe & ~lost;
  end

  // Next-state, counter reload and output-register update
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    pre_d      = pre_q;
    div_d      = div_q;
    data_d     = data_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    count_d    = count_q;

    case (state_q)
      ST_IDLE: begin
        pre_d = '0;
        div_d = 8'd0;
        if (startPulse) begin
          state_d    = ST_RUN;
          overflow_d = 1'b0;
          count_d    = 16'd0;
          pre_d      = PRE_RELOAD;
          div_d      = clock_divisor;
          sel_d      = clock_select;
        end
      end

      ST_RUN: begin
        if (!acq_q) begin
          state_d = ST_IDLE;
          pre_d   = '0;
          div_d   = 8'd0;
        end else begin
          if (!sel_q) begin
            pre_d = (pre_q == '0) ? PRE_RELOAD : pre_q - PW'(1);
          end
          if (baseTick) begin
            if (div_q == 8'd0) begin
              div_d = clock_divisor;
              sel_d = clock_select;
              pre_d = PRE_RELOAD;
              if (lost) begin
                state_d    = ST_OVERFLOW;
                overflow_d = 1'b1;
              end
            end else begin
              div_d = div_q - 8'd1;
            end
          end
        end
      end

      ST_OVERFLOW: begin
        if (!acq_q) begin
          state_d = ST_IDLE;
          pre_d   = '0;
          div_d   = 8'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
    if (capture) begin
      valid_d = 1'b1;
      data_d  = sync_q[SYNC_STAGES-1];
      count_d = count_q + 16'd1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      pre_q      <= '0;
      div_q      <= 8'd0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      pre_q      <= pre_d;
      div_q      <= div_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overflow     = overflow_q;
  assign sample_count = count_q;
  assign running      = (state_q == ST_RUN);

endmodule

// File: tb/tb_sample_strobe_gen.sv
// tb_sample_strobe_gen
// Directed scenarios for sample_strobe_gen with hand-computed expectations.
// Step numbering in every scenario: step 0 is the moment acq_enable is raised
// (just after a clock edge); step k is #1 after the k-th following edge.
module tb_sample_strobe_gen;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             acq_enable;
  logic             clock_select;
  logic [7:0]       clock_divisor;
  logic [WIDTH-1:0] channels;
  logic [WIDTH-1:0] sample_data;
  logic             sample_valid;
  logic             sample_ready;
  logic             overflow;
  logic [15:0]      sample_count;
  logic             running;

  int compared;
  int mismatched;

  sample_strobe_gen #(
    .WIDTH(WIDTH),
    .PRESCALE(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .acq_enable(acq_enable),
    .clock_select(clock_select),
    .clock_divisor(clock_divisor),
    .channels(channels),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overflow(overflow),
    .sample_count(sample_count),
    .running(running)
  );

  // 10 ns system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst          = 1'b0;
    acq_enable   = 1'b0;
    sample_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clock_select  = 1'b1;
    clock_divisor = 8'd0;
    channels      = 16'h1234;
    doReset();
    compared++; if (sample_data !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_data: got %h want 0000", sample_data); end
    compared++; if (sample_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", sample_valid); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    compared++; if (sample_count !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d want 0", sample_count); end
    compared++; if (running !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_running: got %b want 0", running); end
  endtask

  task automatic test_full_rate();
    doReset();
    clock_select  = 1'b1;
    clock_divisor = 8'd0;
    sample_ready  = 1'b1;
    channels      = 16'd0;
    acq_enable    = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      tick();
      if (s < 3) begin
        compared++; if (sample_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL full_valid_early step %0d: got %b want 0", s, sample_valid); end
      end else begin
        compared++; if (sample_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL full_valid step %0d: got %b want 1", s, sample_valid); end
        compared++; if (sample_data !== 16'(s - 3)) begin mismatched++; $display("[TB] FAIL full_data step %0d: got %0d want %0d", s, sample_data, s - 3); end
        compared++; if (sample_count !== 16'(s - 2)) begin mismatched++; $display("[TB] FAIL full_count step %0d: got %0d want %0d", s, sample_count, s - 2); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL full_overflow step %0d: got %b want 0", s, overflow); end
      end
      channels = 16'(s);
    end
  endtask

  task automatic test_divided();
    logic expValid;
    doReset();
    clock_select  = 1'b0;
    clock_divisor = 8'd2;
    sample_ready  = 1'b1;
    channels      = 16'hBEEF;
    acq_enable    = 1'b1;
    for (int s = 1; s <= 62; s++) begin
      tick();
      expValid = (s >= 14) && (((s - 14) % 12) == 0);
      compared++; if (sample_valid !== expValid) begin mismatched++; $display("[TB] FAIL div_valid step %0d: got %b want %b", s, sample_valid, expValid); end
      if (s == 2) begin
        compared++; if (running !== 1'b1) begin mismatched++; $display("[TB] FAIL div_running: got %b want 1", running); end
      end
    end
    compared++; if (sample_count !== 16'd5) begin mismatched++; $display("[TB] FAIL div_count: got %0d want 5", sample_count); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL div_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_backpressure();
    doReset();
    clock_select  = 1'b1;
    clock_divisor = 8'd0;
    sample_ready  = 1'b0;
    channels      = 16'hA5A5;
    acq_enable    = 1'b1;
    tick();
    channels = 16'h5A5A;
    tick();
    tick();
    compared++; if (sample_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_valid1: got %b want 1", sample_valid); end
    compared++; if (sample_data !== 16'hA5A5) begin mismatched++; $display("[TB] FAIL bp_data1: got %h want a5a5", sample_data); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_ovf_before: got %b want 0", overflow); end
    tick();
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_ovf_set: got %b want 1", overflow); end
    compared++; if (running !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_running: got %b want 0", running); end
    compared++; if (sample_count !== 16'd1) begin mismatched++; $display("[TB] FAIL bp_count: got %0d want 1", sample_count); end
    for (int s = 4; s <= 6; s++) begin
      if (s > 4) tick();
      compared++; if (sample_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_hold_valid step %0d: got %b want 1", s, sample_valid); end
      compared++; if (sample_data !== 16'hA5A5) begin mismatched++; $display("[TB] FAIL bp_hold_data step %0d: got %h want a5a5", s, sample_data); end
    end
    sample_ready = 1'b1;
    for (int s = 7; s <= 10; s++) begin
      tick();
      compared++; if (sample_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_drain_valid step %0d: got %b want 0", s, sample_valid); end
    end
    compared++; if (sample_count !== 16'd1) begin mismatched++; $display("[TB] FAIL bp_count_after: got %0d want 1", sample_count); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_ovf_sticky: got %b want 1", overflow); end
    acq_enable = 1'b0;
    tick();
    tick();
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_ovf_idle: got %b want 1", overflow); end
    acq_enable = 1'b1;
    tick();
    tick();
    compared++; if (running !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_restart_running: got %b want 1", running); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_restart_ovf: got %b want 0", overflow); end
    compared++; if (sample_count !== 16'd0) begin mismatched++; $display("[TB] FAIL bp_restart_count: got %0d want 0", sample_count); end
  endtask

  task automatic test_back_to_back();
    doReset();
    clock_select  = 1'b1;
    clock_divisor = 8'd2;
    sample_ready  = 1'b0;
    channels      = 16'd0;
    acq_enable    = 1'b1;
    for (int s = 1; s <= 17; s++) begin
      tick();
      if ((s >= 5) && ((s % 3) == 2)) begin
        compared++; if (sample_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_valid step %0d: got %b want 1", s, sample_valid); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_ovf step %0d: got %b want 0", s, overflow); end
        compared++; if (sample_count !== 16'((s - 2) / 3)) begin mismatched++; $display("[TB] FAIL b2b_count step %0d: got %0d want %0d", s, sample_count, (s - 2) / 3); end
        compared++; if (sample_data !== 16'(s - 3)) begin mismatched++; $display("[TB] FAIL b2b_data step %0d: got %0d want %0d", s, sample_data, s - 3); end
      end
      if (s == 6) begin
        compared++; if (sample_data !== 16'd2) begin mismatched++; $display("[TB] FAIL b2b_stable: got %0d want 2", sample_data); end
      end
      channels     = 16'(s);
      sample_ready = (s >= 7) && ((s % 3) == 1);
    end
    compared++; if (running !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_running: got %b want 1", running); end
  endtask

  task automatic test_mid_change();
    logic expValid;
    doReset();
    clock_select  = 1'b1;
    clock_divisor = 8'd3;
    sample_ready  = 1'b1;
    channels      = 16'h0F0F;
    acq_enable    = 1'b1;
    for (int s = 1; s <= 13; s++) begin
      tick();
      if (s >= 6) begin
        expValid = (s == 6) || (s >= 10);
        compared++; if (sample_valid !== expValid) begin mismatched++; $display("[TB] FAIL mid_valid step %0d: got %b want %b", s, sample_valid, expValid); end
      end
      if (s == 6) clock_divisor = 8'd0;
    end
    compared++; if (sample_count !== 16'd5) begin mismatched++; $display("[TB] FAIL mid_count: got %0d want 5", sample_count); end
    acq_enable = 1'b0;
    tick();
    compared++; if (running !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_run14: got %b want 1", running); end
    compared++; if (sample_count !== 16'd6) begin mismatched++; $display("[TB] FAIL mid_count14: got %0d want 6", sample_count); end
    sample_ready = 1'b0;
    tick();
    compared++; if (running !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_stop: got %b want 0", running); end
    compared++; if (sample_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_pending15: got %b want 1", sample_valid); end
    tick();
    compared++; if (sample_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_pending16: got %b want 1", sample_valid); end
    sample_ready = 1'b1;
    tick();
    compared++; if (sample_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_drained: got %b want 0", sample_valid); end
    compared++; if (sample_count !== 16'd6) begin mismatched++; $display("[TB] FAIL mid_count_hold: got %0d want 6", sample_count); end
    acq_enable = 1'b1;
    tick();
    tick();
    compared++; if (running !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_restart: got %b want 1", running); end
    compared++; if (sample_count !== 16'd0) begin mismatched++; $display("[TB] FAIL mid_restart_count: got %0d want 0", sample_count); end
  endtask

  task automatic test_reset_mid();
    doReset();
    clock_select  = 1'b1;
    clock_divisor = 8'd0;
    sample_ready  = 1'b0;
    channels      = 16'hC3C3;
    acq_enable    = 1'b1;
    for (int s = 1; s <= 4; s++) tick();
    compared++; if ({sample_valid, overflow} !== 2'b11) begin mismatched++; $display("[TB] FAIL rm_pre: got %b want 11", {sample_valid, overflow}); end
    rst        = 1'b0;
    acq_enable = 1'b0;
    tick();
    compared++; if (sample_data !== 16'h0000) begin mismatched++; $display("[TB] FAIL rm_data: got %h want 0000", sample_data); end
    compared++; if (sample_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_valid: got %b want 0", sample_valid); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_overflow: got %b want 0", overflow); end
    compared++; if (sample_count !== 16'd0) begin mismatched++; $display("[TB] FAIL rm_count: got %0d want 0", sample_count); end
    compared++; if (running !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_running: got %b want 0", running); end
    rst = 1'b1;
    for (int s = 6; s <= 8; s++) begin
      tick();
      compared++; if ({running, sample_valid} !== 2'b00) begin mismatched++; $display("[TB] FAIL rm_idle step %0d: got %b want 00", s, {running, sample_valid}); end
    end
    acq_enable = 1'b1;
    tick();
    tick();
    compared++; if (running !== 1'b1) begin mismatched++; $display("[TB] FAIL rm_resume_running: got %b want 1", running); end
    tick();
    compared++; if (sample_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL rm_resume_valid: got %b want 1", sample_valid); end
    compared++; if (sample_data !== 16'hC3C3) begin mismatched++; $display("[TB] FAIL rm_resume_data: got %h want c3c3", sample_data); end
    compared++; if (sample_count !== 16'd1) begin mismatched++; $display("[TB] FAIL rm_resume_count: got %0d want 1", sample_count); end
  endtask

  // Scenario sequence
  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b0;
    acq_enable    = 1'b0;
    clock_select  = 1'b0;
    clock_divisor = 8'd0;
    channels      = '0;
    sample_ready  = 1'b0;
    test_reset();
    test_full_rate();
    test_divided();
    test_backpressure();
    test_back_to_back();
    test_mid_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sample_strobe_gen.md
Name: sample_strobe_gen

Overview:
- Downstream consumer of the register-file block's acq_enable, clock_select and clock_divisor outputs.
- Generates the sample-rate strobe and captures the synchronized logic-analyzer channel inputs on each strobe.
- Presents each captured word on a valid/ready output register to the sample FIFO/packer.
- Detects and flags overflow when the consumer stalls.

Parameters:
WIDTH, 16, number of channel inputs / sample word width
PRESCALE, 4, base-tick period in clk cycles when clock_select=0 (>=2)
SYNC_STAGES, 2, flip-flop stages on the channel inputs (>=2)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous reset, active-low (0 = reset)
acq_enable  in  1  level; 1 = acquisition running
clock_select  in  1  1 = base tick every clk; 0 = base tick every PRESCALE clks
clock_divisor  in  8  strobe every (clock_divisor+1) base ticks
channels  in  WIDTH  asynchronous probe inputs
sample_data  out  WIDTH  captured sample word
sample_valid  out  1  sample_data holds an unconsumed word
sample_ready  in  1  consumer accepts word when sample_valid & sample_ready
overflow  out  1  sticky: strobe lost because output register was full
sample_count  out  16  words captured since acquisition start, wraps 0xFFFF->0
running  out  1  state == RUN

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all outputs 0; prescaler, divider counter and sync chain cleared.
- Channels pass through SYNC_STAGES flops. The captured value is the last stage's output.
- acq_enable is registered once internally (acq_q). Start is detected on acq_q rising edge.
- States:
  - IDLE: counters held at 0. On start -> RUN; clear overflow and sample_count; load prescaler and divider from current inputs.
  - RUN: on acq_q=0 -> IDLE. On a lost strobe -> OVERFLOW.
  - OVERFLOW: no captures. On acq_q=0 -> IDLE; overflow stays 1 until next start.
- Base tick:
  - clock_select=1: every cycle in RUN.
  - clock_select=0: a prescaler counts PRESCALE-1 down to 0 and ticks at 0.
- Divider counter:
  - Loaded with clock_divisor on start and on each strobe.
  - Decrements on base tick; the strobe fires on the base tick at which it reads 0.
  - clock_divisor=0 with clock_select=1 gives a strobe every clk (full rate).
- clock_select and clock_divisor are sampled only at counter reload (start or strobe). A mid-period change affects the following period, never the current one.
- First strobe after start: (clock_divisor+1) base ticks after entering RUN. The start cycle itself is not a tick.
- Capture latency: strobe at cycle N loads sample_data and sets sample_valid at the N+1 edge; sample_count increments at the same edge.
- Handshake:
  - sample_data and sample_valid are stable while sample_valid=1 and sample_ready=0.
  - Transfer occurs on any cycle with sample_valid & sample_ready.
  - Strobe and transfer in the same cycle: new word loads, sample_valid stays 1, no overflow.
  - Strobe with sample_valid=1 and sample_ready=0: word discarded, overflow=1 next cycle, state -> OVERFLOW. The held word is retained and still drains normally.
- acq_enable low: capture stops. A pending word stays valid until consumed. sample_count and overflow hold their values.
- Reset mid-operation: immediate return to reset values, including dropping a pending sample_valid.
- sample_count wraps modulo 2^16 without affecting other behaviour.

Test Plan:
1. Full rate: clock_select=1, divisor=0, sample_ready=1, channels counting 0,1,2... -> sample_valid high every cycle after first strobe; data = channels delayed SYNC_STAGES+1 cycles; overflow=0.
2. Divided rate: clock_select=0, PRESCALE=4, divisor=2 -> strobes spaced exactly 12 clks; first sample_valid 13 clks after acq_q rises; sample_count=5 after 5 strobes.
3. Backpressure: divisor=0, clock_select=1, sample_ready=0 -> first word held stable; overflow=1 one cycle after second strobe; state OVERFLOW. Raising sample_ready drains exactly one word; no further captures.
4. Simultaneous strobe and accept with sample_ready toggled on every strobe cycle -> no overflow; every strobe produces a word.
5. Mid-run change: divisor 3->0 one cycle after a strobe -> next period still 4 ticks, following periods 1 tick. Then drop acq_enable -> running=0 within 2 cycles, pending word drains, re-raise clears overflow and sample_count.
6. rst=0 asserted while sample_valid=1 and overflow=1 -> next edge: all outputs 0, state IDLE; capture resumes only after a new acq_enable rising edge.
